dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Parametrised N-channel round-robin arbiter that multiplexes independent requesters (CPU data port, host/packet loader, debug reader) onto one synchronous port of the data memory. It replaces the tied-off second memory port in the top level. All requesters then share a single arbitrated port with a req/gnt/rvalid handshake and a configurable read-latency pipeline. It sits between the requesters and `d_mem` port A/B in `top`.

## Interface
- `NUM_CH`, 2: number of requester channels, 2..8.
- `ADDR_W`, `` `DMEM_ADDR_WIDTH``: memory word address width.
- `DATA_W`, `` `DATA_WIDTH``: memory data width.
- `RD_LAT`, 1: memory read latency in cycles, 1 or 2.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req_i`  in  NUM_CH  per-channel access request.
- `we_i`  in  NUM_CH  per-channel write flag; 1 = write, 0 = read.
- `lock_i`  in  NUM_CH  per-channel hold-grant request (used only with `DMEM_ARB_LOCK_EN`).
- `addr_i`  in  NUM_CH*ADDR_W  packed addresses; channel k occupies bits [k*ADDR_W +: ADDR_W].
- `wdata_i`  in  NUM_CH*DATA_W  packed write data, same packing.
- `gnt_o`  out  NUM_CH  one-hot grant; the request is accepted at the rising edge ending this cycle.
- `rvalid_o`  out  NUM_CH  one-hot read-data-valid.
- `rdata_o`  out  DATA_W  read data, qualified by `rvalid_o`.
- `mem_addr_o`  out  ADDR_W  address to memory.
- `mem_din_o`  out  DATA_W  write data to memory.
- `mem_we_o`  out  1  memory write enable.
- `mem_dout_i`  in  DATA_W  memory read data.

## Operation
- One access per cycle is granted to at most one channel. `gnt_o` is combinational from `req_i`, the priority pointer `ptr`, and the lock state.
- Round-robin search starts at `ptr`. The first requesting channel at index ≥ `ptr` (wrapping modulo NUM_CH) wins.
- After a grant to channel k, `ptr` ← (k+1) mod NUM_CH. With no grant, `ptr` holds.
- Winner drives memory combinationally:
  - `mem_addr_o` = winner's address.
  - `mem_din_o` = winner's write data.
  - `mem_we_o` = winner's `we_i`.
- With no request, the memory outputs are 0 and `mem_we_o` = 0.
- Writes: complete at the grant edge. No `rvalid_o` is produced.
- Reads: a RD_LAT-deep shift register carries {valid, one-hot channel}. `rvalid_o` pulses for one cycle, RD_LAT cycles after the grant cycle. `rdata_o` = `mem_dout_i` unregistered.
- A requester must hold `req_i`, `we_i`, `addr_i` and `wdata_i` stable until it sees `gnt_o`. It may deassert `req_i` in the cycle after the grant.
- Back-to-back grants are allowed every cycle, to the same or different channels. Read returns stay in grant order.
- A single channel may hold `req_i` high continuously. It receives a grant every cycle when it is the only requester.
- Request, we or address changes with no grant: ignored, no side effects.

## Timing
- Reset state: `ptr` = 0, read pipeline cleared, lock owner cleared.
- Outputs during reset: `gnt_o`, `rvalid_o` and `mem_we_o` are 0. `rdata_o` follows `mem_dout_i`.
- Reset asserted mid-operation: pending read returns are dropped, with no `rvalid_o` afterward. In the reset cycle, `gnt_o` and `mem_we_o` are forced to 0, so no memory write occurs.
- Grant latency: 0 cycles when a channel is the winner. Worst case with all channels requesting: NUM_CH−1 cycles.
- Read latency, request to `rvalid_o`:
  - RD_LAT = 1: the next cycle.
  - RD_LAT = 2: two cycles later.
- Simultaneous grant and return: a grant in cycle n and a `rvalid_o` from an earlier grant are independent. Both may be high in the same cycle.

## Configuration
- `DMEM_ARB_LOCK_EN` defined: a channel granted in cycle n with `lock_i` high becomes lock owner.
  - While the owner keeps `req_i` and `lock_i` high, it wins every cycle regardless of `ptr` and other requests.
  - The lock releases in the first cycle the owner drops `req_i` or `lock_i`. Arbitration that cycle is normal round-robin.
  - `ptr` still updates on every grant.
- `DMEM_ARB_LOCK_EN` undefined: `lock_i` is ignored, there is no lock-owner register, and arbitration is pure round-robin.

## Structure
- Shared constants in `define.v`:
  - `DATA_WIDTH` and `DMEM_ADDR_WIDTH` already exist there.
  - Add `DMEM_ARB_NUM_CH` and `DMEM_RD_LAT` for the top-level instantiation.
- One sub-module, `rr_arb_pick`: a purely combinational rotate / find-first-set / rotate-back.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and encoded index.
- Pointer, lock and read pipeline live in `dmem_arbiter`.

## Test plan
- Reset, then `req_i`=2'b00 for 3 cycles: `gnt_o`=0, `mem_we_o`=0, `rvalid_o`=0 throughout.
- Channel 0 writes 64'hDEAD_BEEF to addr 5, then channel 1 reads addr 5 (RD_LAT=1):
  - `gnt_o`=01 then 10.
  - `rvalid_o`=10 one cycle after the second grant, with `rdata_o`=64'hDEAD_BEEF.
- NUM_CH=4, all `req_i` held high for 8 cycles: grants are exactly 0,1,2,3,0,1,2,3, with `ptr` wrapping from 3 to 0.
- RD_LAT=2, channel 0 reads addr 1 then addr 2 back-to-back (memory preloaded 11, 22):
  - `rvalid_o`=01 in cycles n+2 and n+3.
  - `rdata_o`=11 then 22.
- Reset asserted one cycle after a read grant (RD_LAT=2): no `rvalid_o` ever appears, and the next grant after reset goes to channel 0.
- With `DMEM_ARB_LOCK_EN`:
  - Channel 1 holds `lock_i` and `req_i` for 4 cycles while channel 0 also requests: four consecutive grants to channel 1, then channel 0 on the release cycle.
  - Without the macro, the same stimulus alternates grants 1,0,1,0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared constants and helpers for the data-memory arbiter.
// Also provides fallback values for the project-wide width macros so the
// block can be built on its own; define.v values take precedence when the
// project include is compiled first.
// Optional feature macro: DMEM_ARB_LOCK_EN (see dmem_arbiter.sv).

`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef DMEM_ADDR_WIDTH
`define DMEM_ADDR_WIDTH 10
`endif
`ifndef DMEM_ARB_NUM_CH
`define DMEM_ARB_NUM_CH 2
`endif
`ifndef DMEM_RD_LAT
`define DMEM_RD_LAT 1
`endif

package dmem_arbiter_pkg;

  localparam int MinRdLat = 1;
  localparam int MaxRdLat = 2;

  // Round-robin pointer successor: one past the winner, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// rr_arb_pick: combinational round-robin picker.
// Finds the first set bit of req at or after index ptr, wrapping modulo N.
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  priority pointer (highest-priority index)
//   gnt  out N   one-hot grant (all zero when req is zero)
//   idx  out IW  encoded index of the granted bit (0 when no grant)

module rr_arb_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;
  logic          found;

  // Walking i = 0..N-1 from ptr is the rotate / find-first-set / rotate-back.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: N-channel round-robin arbiter onto one synchronous data-memory
// port with a req/gnt/rvalid handshake and an RD_LAT-deep read-return pipe.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_i/we_i/lock_i  per-channel request, write flag, hold-grant request
//   addr_i/wdata_i     packed per-channel address / write data
//   gnt_o              one-hot grant (combinational)
//   rvalid_o/rdata_o   one-hot read-valid, read data (mem_dout_i passthrough)
//   mem_addr_o/mem_din_o/mem_we_o/mem_dout_i  memory port
// Optional feature: define DMEM_ARB_LOCK_EN to let a granted channel holding
// lock_i keep the port until it drops req_i or lock_i.

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = `DMEM_ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH-1:0]        we_i,
  input  logic [NUM_CH-1:0]        lock_i,
  input  logic [NUM_CH*ADDR_W-1:0] addr_i,
  input  logic [NUM_CH*DATA_W-1:0] wdata_i,
  output logic [NUM_CH-1:0]        gnt_o,
  output logic [NUM_CH-1:0]        rvalid_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_din_o,
  output logic                     mem_we_o,
  input  logic [DATA_W-1:0]        mem_dout_i
);

  localparam int IW  = $clog2(NUM_CH);
  localparam int Lat = (RD_LAT < MinRdLat) ? MinRdLat :
                       (RD_LAT > MaxRdLat) ? MaxRdLat : RD_LAT;

  logic [IW-1:0]     ptr_q;
  logic [NUM_CH-1:0] pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic [NUM_CH-1:0] win_gnt;
  logic [IW-1:0]     win_idx;
  logic              any_gnt;

  rr_arb_pick #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_pick (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

`ifdef DMEM_ARB_LOCK_EN
  logic              lock_q;
  logic [IW-1:0]     owner_q;
  logic [NUM_CH-1:0] owner_oh;
  logic              lock_hold;

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    // The owner keeps the port only while both its req and lock stay high;
    // the first cycle either drops falls back to plain round-robin.
    lock_hold = lock_q && |(owner_oh & req_i & lock_i);
    win_gnt   = lock_hold ? owner_oh : pick_gnt;
    win_idx   = lock_hold ? owner_q : pick_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      lock_q  <= |(gnt_o & lock_i);
      owner_q <= win_idx;
    end
  end
`else
  logic unused_lock;

  assign win_gnt     = pick_gnt;
  assign win_idx     = pick_idx;
  assign unused_lock = ^lock_i;
`endif

  // Reset gates the grant so no write can slip through the reset cycle.
  assign gnt_o   = rst ? '0 : win_gnt;
  assign any_gnt = |gnt_o;

  always_comb begin
    mem_addr_o = '0;
    mem_din_o  = '0;
    mem_we_o   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt_o[k]) begin
        mem_addr_o = addr_i[k*ADDR_W +: ADDR_W];
        mem_din_o  = wdata_i[k*DATA_W +: DATA_W];
        mem_we_o   = we_i[k];
      end
    end
  end

  // Read-return pipe: bit NUM_CH is valid, low bits the one-hot channel.
  logic [NUM_CH:0] pipe_in;
  logic [NUM_CH:0] pipe_q [Lat];

  assign pipe_in = {any_gnt && !mem_we_o, gnt_o};

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      for (int i = 0; i < Lat; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= pipe_in;
      for (int i = 1; i < Lat; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      if (any_gnt) begin
        ptr_q <= IW'(wrap_inc(int'(win_idx), NUM_CH));
      end
    end
  end

  assign rvalid_o = pipe_q[Lat-1][NUM_CH] ? pipe_q[Lat-1][NUM_CH-1:0] : '0;
  assign rdata_o  = mem_dout_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- u0: 2 channels, RD_LAT=1 ----------------
  logic          rst0;
  logic [1:0]    req0, we0, lock0, gnt0, rvalid0;
  logic [2*AW-1:0] addr0;
  logic [2*DW-1:0] wdata0;
  logic [DW-1:0] rdata0, m0_din, m0_dout;
  logic [AW-1:0] m0_addr;
  logic          m0_we;
  logic [DW-1:0] mem0 [256];

  dmem_arbiter #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u0 (
    .clk        (clk),
    .rst        (rst0),
    .req_i      (req0),
    .we_i       (we0),
    .lock_i     (lock0),
    .addr_i     (addr0),
    .wdata_i    (wdata0),
    .gnt_o      (gnt0),
    .rvalid_o   (rvalid0),
    .rdata_o    (rdata0),
    .mem_addr_o (m0_addr),
    .mem_din_o  (m0_din),
    .mem_we_o   (m0_we),
    .mem_dout_i (m0_dout)
  );

  always @(posedge clk) begin
    if (m0_we) mem0[m0_addr] <= m0_din;
    m0_dout <= mem0[m0_addr];
  end

  // ---------------- u4: 4 channels, RD_LAT=1 ----------------
  logic          rst4;
  logic [3:0]    req4, we4, lock4, gnt4, rvalid4;
  logic [4*AW-1:0] addr4;
  logic [4*DW-1:0] wdata4;
  logic [DW-1:0] rdata4, m4_din, m4_dout;
  logic [AW-1:0] m4_addr;
  logic          m4_we;
  logic [DW-1:0] mem4 [256];

  dmem_arbiter #(.NUM_CH(4), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u4 (
    .clk        (clk),
    .rst        (rst4),
    .req_i      (req4),
    .we_i       (we4),
    .lock_i     (lock4),
    .addr_i     (addr4),
    .wdata_i    (wdata4),
    .gnt_o      (gnt4),
    .rvalid_o   (rvalid4),
    .rdata_o    (rdata4),
    .mem_addr_o (m4_addr),
    .mem_din_o  (m4_din),
    .mem_we_o   (m4_we),
    .mem_dout_i (m4_dout)
  );

  always @(posedge clk) begin
    if (m4_we) mem4[m4_addr] <= m4_din;
    m4_dout <= mem4[m4_addr];
  end

  // ---------------- u2: 2 channels, RD_LAT=2 ----------------
  logic          rst2;
  logic [1:0]    req2, we2, lock2, gnt2, rvalid2;
  logic [2*AW-1:0] addr2;
  logic [2*DW-1:0] wdata2;
  logic [DW-1:0] rdata2, m2_din, m2_dout, m2_d1;
  logic [AW-1:0] m2_addr;
  logic          m2_we;
  logic [DW-1:0] mem2 [256];

  dmem_arbiter #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u2 (
    .clk        (clk),
    .rst        (rst2),
    .req_i      (req2),
    .we_i       (we2),
    .lock_i     (lock2),
    .addr_i     (addr2),
    .wdata_i    (wdata2),
    .gnt_o      (gnt2),
    .rvalid_o   (rvalid2),
    .rdata_o    (rdata2),
    .mem_addr_o (m2_addr),
    .mem_din_o  (m2_din),
    .mem_we_o   (m2_we),
    .mem_dout_i (m2_dout)
  );

  always @(posedge clk) begin
    if (m2_we) mem2[m2_addr] <= m2_din;
    m2_d1   <= mem2[m2_addr];
    m2_dout <= m2_d1;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; req0 = 2'b11; we0 = 2'b11;
    addr0 = {AW'(7), AW'(3)}; wdata0 = {DW'(64'h1111), DW'(64'h2222)};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (gnt0 !== 2'b00) begin
        errors++; $display("FAIL reset_gnt cyc%0d got %b want 00", c, gnt0);
      end
      checks++;
      if (m0_we !== 1'b0) begin
        errors++; $display("FAIL reset_we cyc%0d got %b want 0", c, m0_we);
      end
      checks++;
      if (rvalid0 !== 2'b00) begin
        errors++; $display("FAIL reset_rvalid cyc%0d got %b want 00", c, rvalid0);
      end
      next_cycle();
    end
    rst0 = 1'b0; req0 = 2'b00; we0 = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (gnt0 !== 2'b00) begin
        errors++; $display("FAIL idle_gnt cyc%0d got %b want 00", c, gnt0);
      end
      checks++;
      if (m0_we !== 1'b0) begin
        errors++; $display("FAIL idle_we cyc%0d got %b want 0", c, m0_we);
      end
      checks++;
      if (rvalid0 !== 2'b00) begin
        errors++; $display("FAIL idle_rvalid cyc%0d got %b want 00", c, rvalid0);
      end
      next_cycle();
    end
  endtask

  task automatic test_write_read();
    // ch0 writes DEAD_BEEF to addr 5
    req0 = 2'b01; we0 = 2'b01;
    addr0[0 +: AW] = AW'(5); wdata0[0 +: DW] = 64'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (gnt0 !== 2'b01) begin errors++; $display("FAIL wr_gnt got %b want 01", gnt0); end
    checks++;
    if (m0_we !== 1'b1) begin errors++; $display("FAIL wr_we got %b want 1", m0_we); end
    checks++;
    if (m0_addr !== AW'(5)) begin
      errors++; $display("FAIL wr_addr got %0d want 5", m0_addr);
    end
    checks++;
    if (m0_din !== 64'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_din got %h want deadbeef", m0_din);
    end
    next_cycle();
    // ch1 reads addr 5
    req0 = 2'b10; we0 = 2'b00; addr0[AW +: AW] = AW'(5);
    @(negedge clk);
    checks++;
    if (gnt0 !== 2'b10) begin errors++; $display("FAIL rd_gnt got %b want 10", gnt0); end
    checks++;
    if (rvalid0 !== 2'b00) begin
      errors++; $display("FAIL wr_no_rvalid got %b want 00", rvalid0);
    end
    next_cycle();
    req0 = 2'b00;
    @(negedge clk);
    checks++;
    if (rvalid0 !== 2'b10) begin
      errors++; $display("FAIL rd_rvalid got %b want 10", rvalid0);
    end
    checks++;
    if (rdata0 !== 64'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_data got %h want deadbeef", rdata0);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rvalid0 !== 2'b00) begin
      errors++; $display("FAIL rd_rvalid_pulse got %b want 00", rvalid0);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [3:0] prev_g;
    prev_g = 4'b0000;
    req4 = 4'hF; we4 = 4'h0;
    for (int i = 0; i < 8; i++) begin
      exp_g = 4'b0001 << (i % 4);
      @(negedge clk);
      checks++;
      if (gnt4 !== exp_g) begin
        errors++; $display("FAIL rr_gnt cyc%0d got %b want %b", i, gnt4, exp_g);
      end
      checks++;
      if (rvalid4 !== prev_g) begin
        errors++; $display("FAIL rr_rvalid cyc%0d got %b want %b", i, rvalid4, prev_g);
      end
      prev_g = exp_g;
      next_cycle();
    end
    req4 = 4'h0;
    @(negedge clk);
    checks++;
    if (rvalid4 !== 4'b1000) begin
      errors++; $display("FAIL rr_last_rvalid got %b want 1000", rvalid4);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back_lat2();
    req2 = 2'b01; we2 = 2'b00; addr2[0 +: AW] = AW'(1);
    @(negedge clk);
    checks++;
    if (gnt2 !== 2'b01) begin errors++; $display("FAIL b2b_gnt0 got %b want 01", gnt2); end
    next_cycle();
    addr2[0 +: AW] = AW'(2);
    @(negedge clk);
    checks++;
    if (gnt2 !== 2'b01) begin errors++; $display("FAIL b2b_gnt1 got %b want 01", gnt2); end
    checks++;
    if (rvalid2 !== 2'b00) begin
      errors++; $display("FAIL b2b_early got %b want 00", rvalid2);
    end
    next_cycle();
    req2 = 2'b00;
    @(negedge clk);
    checks++;
    if (rvalid2 !== 2'b01) begin errors++; $display("FAIL b2b_rv0 got %b want 01", rvalid2); end
    checks++;
    if (rdata2 !== 64'd11) begin errors++; $display("FAIL b2b_rd0 got %0d want 11", rdata2); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rvalid2 !== 2'b01) begin errors++; $display("FAIL b2b_rv1 got %b want 01", rvalid2); end
    checks++;
    if (rdata2 !== 64'd22) begin errors++; $display("FAIL b2b_rd1 got %0d want 22", rdata2); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rvalid2 !== 2'b00) begin errors++; $display("FAIL b2b_rv2 got %b want 00", rvalid2); end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    req2 = 2'b01; we2 = 2'b00; addr2[0 +: AW] = AW'(1);
    @(negedge clk);
    checks++;
    if (gnt2 !== 2'b01) begin errors++; $display("FAIL mid_gnt got %b want 01", gnt2); end
    next_cycle();
    rst2 = 1'b1; req2 = 2'b11; we2 = 2'b11;
    @(negedge clk);
    checks++;
    if (gnt2 !== 2'b00) begin errors++; $display("FAIL mid_rst_gnt got %b want 00", gnt2); end
    checks++;
    if (m2_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we got %b want 0", m2_we); end
    next_cycle();
    rst2 = 1'b0; req2 = 2'b00; we2 = 2'b00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (rvalid2 !== 2'b00) begin
        errors++; $display("FAIL mid_dropped cyc%0d got %b want 00", c, rvalid2);
      end
      next_cycle();
    end
    req2 = 2'b11;
    @(negedge clk);
    checks++;
    if (gnt2 !== 2'b01) begin errors++; $display("FAIL mid_ptr got %b want 01", gnt2); end
    next_cycle();
    req2 = 2'b00;
    next_cycle();
  endtask

  task automatic test_lock();
    logic [1:0] exp_g [5];
`ifdef DMEM_ARB_LOCK_EN
    exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b10; exp_g[3] = 2'b10; exp_g[4] = 2'b01;
`else
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01; exp_g[4] = 2'b10;
`endif
    rst0 = 1'b1; req0 = 2'b00; we0 = 2'b00; lock0 = 2'b00;
    next_cycle();
    rst0 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req0  = (c == 0) ? 2'b10 : 2'b11;
      lock0 = (c < 4) ? 2'b10 : 2'b00;
      @(negedge clk);
      checks++;
      if (gnt0 !== exp_g[c]) begin
        errors++; $display("FAIL lock_gnt cyc%0d got %b want %b", c, gnt0, exp_g[c]);
      end
      next_cycle();
    end
    req0 = 2'b00; lock0 = 2'b00;
    next_cycle();
  endtask

  initial begin
    rst0 = 1'b1; rst4 = 1'b1; rst2 = 1'b1;
    req0 = '0; we0 = '0; lock0 = '0; addr0 = '0; wdata0 = '0;
    req4 = '0; we4 = '0; lock4 = '0; addr4 = '0; wdata4 = '0;
    req2 = '0; we2 = '0; lock2 = '0; addr2 = '0; wdata2 = '0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = '0; mem4[i] = '0; mem2[i] = '0;
    end
    mem2[1] = 64'd11;
    mem2[2] = 64'd22;
    repeat (2) @(posedge clk);
    #1;
    rst4 = 1'b0; rst2 = 1'b0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back_lat2();
    test_reset_mid_read();
    test_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
